scan_packet_tx: RTL and testbench
=================================

# scan_packet_tx

Serialises one scan packet from a local 16-bit sample buffer onto a UART line at 8N1. The frame is header 0x55 0xAA, then CT, FSA, LSA and CT samples, with all 16-bit fields little-endian. The block is the transmit end of the scan-packet link: it drives a UART line that the scan-packet receiver consumes, either as a LiDAR emulator for bench/loopback or as the sensor-side framer. A host fills the buffer, pulses `start`, and the block streams the frame back-to-back with no inter-byte gaps.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200).
- `MAX_SAMPLES`, default 128: buffer depth; legal CT is 1..MAX_SAMPLES.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `wr_en` in 1: sample buffer write strobe.
- `wr_addr` in 7: sample index (`$clog2(MAX_SAMPLES)`).
- `wr_data` in 16: sample distance.
- `start` in 1: one-cycle request to send a frame.
- `ct` in 8: sample count; latched on an accepted `start`.
- `fsa` in 16: first-sample angle; latched on an accepted `start`.
- `lsa` in 16: last-sample angle; latched on an accepted `start`.
- `serial` out 1: UART TX line, idle high.
- `busy` out 1: a frame is in progress.
- `done` out 1: one-cycle pulse when a frame completes.
- `err` out 1: one-cycle pulse when `start` is rejected.

## Operation
- Reset values: `serial`=1, `busy`=0, `done`=0, `err`=0, FSM=IDLE. The buffer RAM is not cleared.
- Writes: `wr_en` writes `wr_data` to `buf[wr_addr]` only while `busy`=0. Writes are ignored while `busy`=1.
- Start acceptance: `start` with `busy`=0 and 1≤`ct`≤MAX_SAMPLES is accepted. `ct`, `fsa` and `lsa` are latched.
- Start rejection: `start` with `ct`=0 or `ct`>MAX_SAMPLES pulses `err` on the next cycle; `busy` stays 0 and nothing is sent.
- `start` while `busy`=1 is ignored, with no `err`.
- FSM: IDLE → HDR0 (0x55) → HDR1 (0xAA) → CT → FSA_L → FSA_H → LSA_L → LSA_H → SMP_L → SMP_H.
  - SMP_H loops back to SMP_L until index = ct-1.
  - After the last SMP_H: → [CS] → FIN → IDLE.
- Sample index runs 0..ct-1. `buf[idx][7:0]` is sent before `buf[idx][15:8]`.
- Each byte is sent as: start bit 0, data bits LSB first, stop bit 1. Every bit lasts exactly CLKS_PER_BIT cycles.
- Reset mid-frame: `serial` returns high on the next cycle and the FSM goes to IDLE with no `done`. The next accepted `start` sends a complete frame.
- `reset` takes priority over `start` in the same cycle.

## Timing
- `start` accepted at edge N: `busy`=1 from N+1, and the first start bit drives `serial`=0 from N+2.
- Bytes are back-to-back. The stop bit of byte k is followed directly by the start bit of byte k+1.
- Frame length is B = 7+2·ct bytes (8+2·ct with checksum). The line is busy for B·10·CLKS_PER_BIT cycles.
- On the cycle after the final stop bit: `done`=1 and `busy`=0 together, and `serial` stays high.
- A new `start` is accepted on the same cycle that `done` is high.
- The sample buffer read is synchronous. The next byte must be ready when the stop bit of the current byte ends.

## Configuration
- `SCAN_TX_CHECKSUM_EN` defined: one extra byte follows the last sample. It is the 8-bit XOR of every preceding frame byte, headers included. Frame = 8+2·ct bytes.
- `SCAN_TX_CHECKSUM_EN` undefined: no CS state and no checksum logic. Frame = 7+2·ct bytes.

## Structure
- Package `scan_pkt_pkg` holds:
  - `HDR0`=8'h55 and `HDR1`=8'hAA;
  - the FSM state enum;
  - the frame-overhead constant (7).
- The receiver-side logic also imports the package.
- Sub-module `TxD`, the counterpart of `RxD`:
  - ports `clk`, `reset`, `i_start`, `i_byte[7:0]`, `o_busy`, `o_done`, `o_serial`;
  - owns the bit-timing counter and the shift register;
  - `o_done` pulses in the last cycle of the stop bit.
- The framer owns the FSM, the sample index, the latches and the buffer.

## Test plan
- CT=1, FSA=0x1234, LSA=0x5678, buf[0]=0x0065 → `serial` decodes to 55 AA 01 34 12 78 56 65 00. `done` arrives 90·CLKS_PER_BIT+2 cycles after `start`. With `SCAN_TX_CHECKSUM_EN`, 0x93 is appended.
- CT=16, all samples 200 except buf[3]=50, looped into the scan-packet receiver → receiver reports CT=16 and obstacle alert = 0x0008. The FSA/LSA it reports match the values sent.
- `start` with ct=0, and separately with ct=MAX_SAMPLES+1 → `err` pulses one cycle, `busy`=0, `serial` stays 1 for 1000 cycles.
- `start` and `wr_en` (buf[0]←0xFFFF) mid-frame → no restart and no `err`; the frame carries the original buf[0]. The write takes effect only once `busy`=0.
- `reset` during SMP_L of sample 2 → `serial`=1 and `busy`=0 the next cycle, and no `done`. A following `start` yields a complete, correct frame.
- CT=MAX_SAMPLES with buf[i]=i → 263 bytes back-to-back, zero gap between bytes, and the index wraps correctly at the last sample.

Source files
------------

// File: rtl/scan_pkt_pkg.sv
// Shared constants and FSM state type for the scan-packet link (transmitter and receiver).
// Optional checksum byte is enabled by defining SCAN_TX_CHECKSUM_EN.
package scan_pkt_pkg;

   localparam logic [7:0] HDR0           = 8'h55;
   localparam logic [7:0] HDR1           = 8'hAA;
   localparam int         FRAME_OVERHEAD = 7;

   typedef enum logic [3:0] {
      S_IDLE,
      S_HDR0,
      S_HDR1,
      S_CT,
      S_FSA_L,
      S_FSA_H,
      S_LSA_L,
      S_LSA_H,
      S_SMP_L,
      S_SMP_H,
`ifdef SCAN_TX_CHECKSUM_EN
      S_CS,
`endif
      S_FIN
   } tx_state_e;

endpackage

// File: rtl/TxD.sv
// UART 8N1 byte transmitter: owns the bit timer and shift register.
// o_done is high in the last cycle of the stop bit so a following byte can start with no gap.
module TxD #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_start,
   input  logic [7:0] i_byte,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_serial
);

   localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

   logic          active_r;
   logic [3:0]    bit_idx_r;
   logic [CW-1:0] clk_cnt_r;
   logic [8:0]    shift_r;
   logic          serial_r;
   logic          done_r;
   logic          stop_end_s;

   assign stop_end_s = (bit_idx_r == 4'd9) && (clk_cnt_r == LAST);

   // Bit timing: a new byte is accepted when idle or exactly at the end of the stop bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         active_r  <= 1'b0;
         bit_idx_r <= 4'd0;
         clk_cnt_r <= '0;
         shift_r   <= 9'h1FF;
         serial_r  <= 1'b1;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (!active_r || stop_end_s) begin
            bit_idx_r <= 4'd0;
            clk_cnt_r <= '0;
            if (i_start) begin
               active_r <= 1'b1;
               serial_r <= 1'b0;
               shift_r  <= {1'b1, i_byte};
            end else begin
               active_r <= 1'b0;
               serial_r <= 1'b1;
            end
         end else if (clk_cnt_r == LAST) begin
            clk_cnt_r <= '0;
            bit_idx_r <= bit_idx_r + 4'd1;
            serial_r  <= shift_r[0];
            shift_r   <= {1'b1, shift_r[8:1]};
         end else begin
            clk_cnt_r <= clk_cnt_r + CW'(1);
            if ((bit_idx_r == 4'd9) && (clk_cnt_r == PRE)) begin
               done_r <= 1'b1;
            end
         end
      end
   end

   assign o_busy   = active_r;
   assign o_done   = done_r;
   assign o_serial = serial_r;

endmodule

// File: rtl/scan_packet_tx.sv
// Scan-packet framer: buffers 16-bit samples and streams 55 AA CT FSA LSA samples over UART 8N1.
// Defining SCAN_TX_CHECKSUM_EN appends an XOR checksum byte of all preceding frame bytes.
module scan_packet_tx
   import scan_pkt_pkg::*;
#(
   parameter  int CLKS_PER_BIT = 434,
   parameter  int MAX_SAMPLES  = 128,
   localparam int AW           = $clog2(MAX_SAMPLES)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [15:0]   wr_data,
   input  logic          start,
   input  logic [7:0]    ct,
   input  logic [15:0]   fsa,
   input  logic [15:0]   lsa,
   output logic          serial,
   output logic          busy,
   output logic          done,
   output logic          err
);

   tx_state_e     state_r;
   tx_state_e     next_state_s;
   logic          busy_r;
   logic          done_r;
   logic          err_r;
   logic          launch_r;
   logic [AW-1:0] idx_r;
   logic [7:0]    ct_r;
   logic [15:0]   fsa_r;
   logic [15:0]   lsa_r;
   logic [15:0]   rd_data_r;
   logic [15:0]   mem [MAX_SAMPLES];
`ifdef SCAN_TX_CHECKSUM_EN
   logic [7:0]    cs_r;
`endif

   logic          ct_ok_s;
   logic          last_smp_s;
   logic          tx_start_s;
   logic          tx_done_s;
   logic          tx_busy_s;
   logic [7:0]    tx_byte_s;

   assign ct_ok_s    = (ct != 8'd0) && (32'(ct) <= 32'(MAX_SAMPLES));
   assign last_smp_s = (8'(idx_r) == (ct_r - 8'd1));
   // Next byte is handed over in the last stop-bit cycle of the current one, giving zero gap.
   assign tx_start_s = (launch_r & ~tx_busy_s) | (tx_done_s & (state_r != S_FIN));

   // Sample buffer: writable only while idle; read port is registered.
   always_ff @(posedge clk) begin
      if (wr_en && !busy_r) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data_r <= mem[idx_r];
   end

   // Byte presented to the transmitter for the current state.
   always_comb begin
      tx_byte_s = 8'h00;
      case (state_r)
         S_HDR0:  tx_byte_s = HDR0;
         S_HDR1:  tx_byte_s = HDR1;
         S_CT:    tx_byte_s = ct_r;
         S_FSA_L: tx_byte_s = fsa_r[7:0];
         S_FSA_H: tx_byte_s = fsa_r[15:8];
         S_LSA_L: tx_byte_s = lsa_r[7:0];
         S_LSA_H: tx_byte_s = lsa_r[15:8];
         S_SMP_L: tx_byte_s = rd_data_r[7:0];
         S_SMP_H: tx_byte_s = rd_data_r[15:8];
`ifdef SCAN_TX_CHECKSUM_EN
         S_CS:    tx_byte_s = cs_r;
`endif
         default: tx_byte_s = 8'h00;
      endcase
   end

   // State reached once the current byte has been handed to the transmitter.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         S_HDR0:  next_state_s = S_HDR1;
         S_HDR1:  next_state_s = S_CT;
         S_CT:    next_state_s = S_FSA_L;
         S_FSA_L: next_state_s = S_FSA_H;
         S_FSA_H: next_state_s = S_LSA_L;
         S_LSA_L: next_state_s = S_LSA_H;
         S_LSA_H: next_state_s = S_SMP_L;
         S_SMP_L: next_state_s = S_SMP_H;
`ifdef SCAN_TX_CHECKSUM_EN
         S_SMP_H: next_state_s = last_smp_s ? S_CS : S_SMP_L;
         S_CS:    next_state_s = S_FIN;
`else
         S_SMP_H: next_state_s = last_smp_s ? S_FIN : S_SMP_L;
`endif
         default: next_state_s = state_r;
      endcase
   end

   // Framer FSM, field latches, sample index and status pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= S_IDLE;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
         launch_r <= 1'b0;
         idx_r    <= '0;
         ct_r     <= 8'd0;
         fsa_r    <= 16'd0;
         lsa_r    <= 16'd0;
`ifdef SCAN_TX_CHECKSUM_EN
         cs_r     <= 8'd0;
`endif
      end else begin
         done_r   <= 1'b0;
         err_r    <= 1'b0;
         launch_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  if (ct_ok_s) begin
                     state_r  <= S_HDR0;
                     busy_r   <= 1'b1;
                     launch_r <= 1'b1;
                     idx_r    <= '0;
                     ct_r     <= ct;
                     fsa_r    <= fsa;
                     lsa_r    <= lsa;
`ifdef SCAN_TX_CHECKSUM_EN
                     cs_r     <= 8'd0;
`endif
                  end else begin
                     err_r <= 1'b1;
                  end
               end
            end
            S_FIN: begin
               if (tx_done_s) begin
                  state_r <= S_IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end
            end
            default: begin
               if (tx_start_s) begin
                  state_r <= next_state_s;
`ifdef SCAN_TX_CHECKSUM_EN
                  cs_r    <= cs_r ^ tx_byte_s;
`endif
                  if ((state_r == S_SMP_H) && !last_smp_s) begin
                     idx_r <= idx_r + AW'(1);
                  end
               end
            end
         endcase
      end
   end

   TxD #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_txd (
      .clk      (clk),
      .reset    (reset),
      .i_start  (tx_start_s),
      .i_byte   (tx_byte_s),
      .o_busy   (tx_busy_s),
      .o_done   (tx_done_s),
      .o_serial (serial)
   );

   assign busy = busy_r;
   assign done = done_r;
   assign err  = err_r;

endmodule

// File: tb/tb_scan_packet_tx.sv
// Self-checking bench for scan_packet_tx: every UART bit is checked at its exact cycle
// against a frame built from a reference copy of the sample buffer.
module tb_scan_packet_tx;

   localparam int CPB  = 8;
   localparam int MAXS = 128;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [6:0]  wr_addr;
   logic [15:0] wr_data;
   logic        start;
   logic [7:0]  ct;
   logic [15:0] fsa;
   logic [15:0] lsa;
   logic        serial;
   logic        busy;
   logic        done;
   logic        err;

   int vectors     = 0;
   int miscompares = 0;
   int done_cnt    = 0;
   int err_cnt     = 0;

   logic [15:0] ref_mem [MAXS];
   logic [7:0]  exp_q [$];

   scan_packet_tx #(
      .CLKS_PER_BIT(CPB),
      .MAX_SAMPLES (MAXS)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .start   (start),
      .ct      (ct),
      .fsa     (fsa),
      .lsa     (lsa),
      .serial  (serial),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (err === 1'b1) err_cnt++;
   end

   task automatic write_buf(input int a, input logic [15:0] d);
      wr_en   = 1'b1;
      wr_addr = 7'(a);
      wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic build_expected(input logic [7:0] c, input logic [15:0] f, input logic [15:0] l);
      logic [7:0] x;
      exp_q.delete();
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hAA);
      exp_q.push_back(c);
      exp_q.push_back(f[7:0]);
      exp_q.push_back(f[15:8]);
      exp_q.push_back(l[7:0]);
      exp_q.push_back(l[15:8]);
      for (int i = 0; i < int'(c); i++) begin
         exp_q.push_back(ref_mem[i][7:0]);
         exp_q.push_back(ref_mem[i][15:8]);
      end
`ifdef SCAN_TX_CHECKSUM_EN
      x = 8'h00;
      foreach (exp_q[i]) x = x ^ exp_q[i];
      exp_q.push_back(x);
`else
      x = 8'h00;
`endif
   endtask

   // Drives start now (caller is just after a negedge) and checks the whole frame bit by bit.
   // act_byte >= 0 injects a start and a buf[0] write during that byte.
   task automatic check_frame(input logic [7:0] c, input logic [15:0] f, input logic [15:0] l,
                              input int act_byte);
      logic [9:0] w, first, last;
      logic       st_ok;
      int         e0;
      e0 = err_cnt;
      build_expected(c, f, l);
      start = 1'b1; ct = c; fsa = f; lsa = l;
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (busy !== 1'b1 || serial !== 1'b1 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL accept ct=%0d: busy=%b serial=%b done=%b expected 1 1 0", c, busy, serial, done);
      end
      @(negedge clk);
      foreach (exp_q[k]) begin
         w = {1'b1, exp_q[k], 1'b0};
         st_ok = 1'b1;
         for (int j = 0; j < 10; j++) begin
            first[j] = serial;
            if (k == act_byte && j == 2) begin
               start = 1'b1; ct = 8'd5;
               wr_en = 1'b1; wr_addr = 7'd0; wr_data = 16'hFFFF;
            end
            for (int t = 1; t < CPB; t++) begin
               @(negedge clk);
               start = 1'b0; wr_en = 1'b0;
            end
            last[j] = serial;
            if (busy !== 1'b1 || done !== 1'b0) st_ok = 1'b0;
            @(negedge clk);
         end
         vectors++;
         if (first !== w || last !== w || !st_ok) begin
            miscompares++;
            $display("FAIL byte %0d of ct=%0d frame: got bits %b/%b status_ok=%b expected %b",
                     k, c, first, last, st_ok, w);
         end
      end
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0 || serial !== 1'b1 || err_cnt != e0) begin
         miscompares++;
         $display("FAIL frame end ct=%0d: done=%b busy=%b serial=%b errs=%0d expected 1 0 1 0",
                  c, done, busy, serial, err_cnt - e0);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = 7'd0; wr_data = 16'd0;
      ct = 8'd0; fsa = 16'd0; lsa = 16'd0;
      repeat (3) @(negedge clk);
      vectors++;
      if (serial !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset: serial=%b busy=%b done=%b err=%b expected 1 0 0 0", serial, busy, done, err);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      write_buf(0, 16'h0065);
      check_frame(8'd1, 16'h1234, 16'h5678, -1);
      @(negedge clk);
   endtask

   task automatic test_random();
      int c;
      for (int n = 0; n < 6; n++) begin
         c = $urandom_range(1, 12);
         for (int i = 0; i < c; i++) write_buf(i, 16'($urandom));
         check_frame(8'(c), 16'($urandom), 16'($urandom), -1);
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) write_buf(i, 16'($urandom));
      check_frame(8'd3, 16'($urandom), 16'($urandom), -1);
      check_frame(8'd6, 16'($urandom), 16'($urandom), -1);
      check_frame(8'd1, 16'($urandom), 16'($urandom), -1);
      @(negedge clk);
   endtask

   task automatic test_reject();
      logic [7:0] bad_ct [3];
      logic       bad;
      int         e0;
      bad_ct[0] = 8'd0;
      bad_ct[1] = 8'(MAXS + 1);
      bad_ct[2] = 8'($urandom_range(MAXS + 2, 255));
      for (int n = 0; n < 3; n++) begin
         e0 = err_cnt;
         start = 1'b1; ct = bad_ct[n];
         @(negedge clk);
         start = 1'b0;
         vectors++;
         if (err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reject ct=%0d: err=%b busy=%b expected 1 0", bad_ct[n], err, busy);
         end
         bad = 1'b0;
         repeat (1000) begin
            @(negedge clk);
            if (serial !== 1'b1 || busy !== 1'b0) bad = 1'b1;
         end
         vectors++;
         if (bad || err_cnt != e0 + 1) begin
            miscompares++;
            $display("FAIL reject idle ct=%0d: line_disturbed=%b err_pulses=%0d expected 0 1",
                     bad_ct[n], bad, err_cnt - e0);
         end
      end
   endtask

   task automatic test_midframe();
      write_buf(0, 16'h1357);
      write_buf(1, 16'h9BDF);
      check_frame(8'd2, 16'hA1B2, 16'hC3D4, 3);
      @(negedge clk);
      check_frame(8'd1, 16'h0F0F, 16'hF0F0, -1);
      @(negedge clk);
      write_buf(0, 16'hFFFF);
      check_frame(8'd1, 16'h0F0F, 16'hF0F0, -1);
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic bad;
      int   d0;
      for (int i = 0; i < 4; i++) write_buf(i, 16'($urandom));
      start = 1'b1; ct = 8'd4; fsa = 16'h1111; lsa = 16'h2222;
      @(negedge clk);
      start = 1'b0;
      repeat (3 + 11 * 10 * CPB) @(negedge clk);
      vectors++;
      if (serial !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL sample2 start bit: serial=%b busy=%b expected 0 1", serial, busy);
      end
      reset = 1'b1; start = 1'b1; ct = 8'd4;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      d0 = done_cnt;
      vectors++;
      if (serial !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset mid-frame: serial=%b busy=%b expected 1 0", serial, busy);
      end
      bad = 1'b0;
      repeat (30 * CPB) begin
         @(negedge clk);
         if (serial !== 1'b1 || busy !== 1'b0) bad = 1'b1;
      end
      vectors++;
      if (bad || done_cnt != d0) begin
         miscompares++;
         $display("FAIL after reset: line_disturbed=%b done_pulses=%0d expected 0 0", bad, done_cnt - d0);
      end
      check_frame(8'd4, 16'h3333, 16'h4444, -1);
      @(negedge clk);
   endtask

   task automatic test_max();
      for (int i = 0; i < MAXS; i++) write_buf(i, 16'(i));
      check_frame(8'(MAXS), 16'hBEEF, 16'hCAFE, -1);
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_back_to_back();
      test_reject();
      test_midframe();
      test_reset_mid();
      test_max();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
